soc_fabric: RTL

Parametrised memory-mapped peripheral fabric between the MIPS core's data port and the data memory, a configurable bank of accelerator slots (factorial, FP multiply, and future units) and a bank of general-purpose input ports. It replaces the fixed two-accelerator, single-GPI SoC decode with a req/ack handshake, registered read data, sticky write-1-to-clear done status with interrupt enable, and synchronised GPI inputs.

---
 rtl/soc_fabric_pkg.sv | 51 +++++
 rtl/soc_fabric_gpi_sync.sv | 26 ++
 rtl/soc_fabric.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/soc_fabric_pkg.sv
// Shared address map, FSM states and target decode for the peripheral fabric.
package soc_fabric_pkg;

    localparam logic [11:0] MEM_BASE    = 12'h000;
    localparam logic [11:0] ACC_BASE    = 12'h800;
    localparam int          ACC_STRIDE  = 'h40;
    localparam logic [11:0] GPI_BASE    = 12'hC00;
    localparam logic [11:0] STATUS_ADDR = 12'hD00;
    localparam logic [11:0] IRQ_EN_ADDR = 12'hD04;
    localparam int          ERR_BIT     = 31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_e;

    typedef enum logic [2:0] {
        TGT_MEM,
        TGT_ACC,
        TGT_GPI,
        TGT_STATUS,
        TGT_IRQ_EN,
        TGT_NONE
    } target_e;

    // Slots beyond num_acc and ports beyond gpi_ports fall through to TGT_NONE.
    function automatic target_e decode_target(input logic [31:0] a,
                                              input int num_acc,
                                              input int gpi_ports);
        logic [11:0] off;
        target_e     t;
        off = a[11:0] - ACC_BASE;
        t   = TGT_NONE;
        if (a[31:12] != 20'd0) begin
            t = TGT_NONE;
        end else if ((a[11:0] & 12'h800) == MEM_BASE) begin
            t = TGT_MEM;
        end else if (a[11:10] == ACC_BASE[11:10]) begin
            if (int'(off) / ACC_STRIDE < num_acc) t = TGT_ACC;
        end else if (a[11:8] == GPI_BASE[11:8]) begin
            if (int'(a[7:0]) / 4 < gpi_ports) t = TGT_GPI;
        end else if ({a[11:2], 2'b00} == STATUS_ADDR) begin
            t = TGT_STATUS;
        end else if ({a[11:2], 2'b00} == IRQ_EN_ADDR) begin
            t = TGT_IRQ_EN;
        end
        return t;
    endfunction

endpackage

// File: rtl/soc_fabric_gpi_sync.sv
// Two-flop synchroniser for the asynchronous general-purpose input vector.
module gpi_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/soc_fabric.sv
// Memory-mapped fabric: core req/ack port to data memory, accelerator slots,
// synchronised GPI ports and a sticky done/error STATUS with interrupt enable.
module soc_fabric
    import soc_fabric_pkg::*;
#(
    parameter int NUM_ACC   = 2,
    parameter int GPI_PORTS = 1,
    parameter int GPI_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req,
    input  logic                           we,
    input  logic [31:0]                    addr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata,
    output logic                           ack,
    output logic                           mem_en,
    output logic                           mem_we,
    output logic [8:0]                     mem_addr,
    output logic [31:0]                    mem_wdata,
    input  logic [31:0]                    mem_rdata,
    output logic [NUM_ACC-1:0]             acc_sel,
    output logic                           acc_we,
    output logic [3:0]                     acc_addr,
    output logic [31:0]                    acc_wdata,
    input  logic [32*NUM_ACC-1:0]          acc_rdata,
    input  logic [NUM_ACC-1:0]             acc_done,
    input  logic [GPI_PORTS*GPI_WIDTH-1:0] gpi,
    output logic                           irq
);

    localparam logic [31:0] STS_MASK = {1'b1, {(31-NUM_ACC){1'b0}}, {NUM_ACC{1'b1}}};

    state_e               state_q;
    target_e              target_q;
    target_e              req_tgt;
    logic                 we_q;
    logic [31:0]          wdata_q;
    logic [8:0]           mem_addr_q;
    logic [31:0]          rdata_q;
    logic                 ack_q;
    logic                 mem_en_q;
    logic                 mem_we_q;
    logic [NUM_ACC-1:0]   acc_sel_q;
    logic                 acc_we_q;
    logic [31:0]          status_q, status_d;
    logic [31:0]          irq_en_q, irq_en_d;
    logic                 irq_q;
    logic [NUM_ACC-1:0]   done_prev_q;
    logic [31:0]          read_val;

    logic [GPI_PORTS*GPI_WIDTH-1:0] gpi_sync_w;
    logic [31:0]                    acc_slot [8];
    logic [31:0]                    gpi_word [4];

    gpi_sync #(
        .WIDTH(GPI_PORTS*GPI_WIDTH)
    ) u_gpi_sync (
        .clk  (clk),
        .rst_n(reset),
        .d_i  (gpi),
        .q_o  (gpi_sync_w)
    );

    // Pad both read-source tables to their maximum size so the index never overruns.
    for (genvar gi = 0; gi < 8; gi++) begin : g_acc_slot
        if (gi < NUM_ACC) begin : g_used
            assign acc_slot[gi] = acc_rdata[32*gi +: 32];
        end else begin : g_unused
            assign acc_slot[gi] = '0;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_gpi_word
        if (gi < GPI_PORTS) begin : g_used
            assign gpi_word[gi] = 32'(gpi_sync_w[GPI_WIDTH*gi +: GPI_WIDTH]);
        end else begin : g_unused
            assign gpi_word[gi] = '0;
        end
    end

    always_comb begin
        req_tgt = decode_target(addr, NUM_ACC, GPI_PORTS);
    end

    // mem_addr_q holds addr[10:2]: [6:4] is the slot, [3:0] the register, [1:0] the port.
    always_comb begin
        read_val = '0;
        if (!we_q) begin
            case (target_q)
                TGT_MEM:    read_val = mem_rdata;
                TGT_ACC:    read_val = acc_slot[mem_addr_q[6:4]];
                TGT_GPI:    read_val = gpi_word[mem_addr_q[1:0]];
                TGT_STATUS: read_val = status_q;
                TGT_IRQ_EN: read_val = irq_en_q;
                default:    read_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            target_q   <= TGT_NONE;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            mem_addr_q <= '0;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            acc_sel_q  <= '0;
            acc_we_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        target_q   <= req_tgt;
                        we_q       <= we;
                        wdata_q    <= wdata;
                        mem_addr_q <= addr[10:2];
                        mem_en_q   <= (req_tgt == TGT_MEM);
                        mem_we_q   <= (req_tgt == TGT_MEM) && we;
                        acc_sel_q  <= (req_tgt == TGT_ACC) ? (NUM_ACC'(1) << addr[8:6]) : '0;
                        acc_we_q   <= (req_tgt == TGT_ACC) && we;
                        state_q    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    mem_en_q  <= 1'b0;
                    mem_we_q  <= 1'b0;
                    acc_sel_q <= '0;
                    acc_we_q  <= 1'b0;
                    rdata_q   <= read_val;
                    ack_q     <= 1'b1;
                    state_q   <= ST_RESP;
                end
                ST_RESP: begin
                    ack_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ack_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Clears are applied before new done edges and ERR, so a coincident set wins.
    always_comb begin
        status_d = status_q;
        irq_en_d = irq_en_q;
        if (state_q == ST_ACCESS && we_q && target_q == TGT_STATUS) begin
            status_d = status_q & ~wdata_q;
        end
        if (state_q == ST_ACCESS && we_q && target_q == TGT_IRQ_EN) begin
            irq_en_d = wdata_q & STS_MASK;
        end
        status_d = (status_d | 32'(acc_done & ~done_prev_q)) & STS_MASK;
        if (state_q == ST_ACCESS && target_q == TGT_NONE) begin
            status_d[ERR_BIT] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status_q    <= '0;
            irq_en_q    <= '0;
            irq_q       <= 1'b0;
            done_prev_q <= '0;
        end else begin
            status_q    <= status_d;
            irq_en_q    <= irq_en_d;
            irq_q       <= |(status_q & irq_en_q);
            done_prev_q <= acc_done;
        end
    end

    assign rdata     = rdata_q;
    assign ack       = ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = wdata_q;
    assign acc_sel   = acc_sel_q;
    assign acc_we    = acc_we_q;
    assign acc_addr  = mem_addr_q[3:0];
    assign acc_wdata = wdata_q;
    assign irq       = irq_q;

endmodule
